usb_rx_bit_decoder: RTL and testbench

Receive-side bit-level decoder for the USB full-speed transceiver. Consumes synchronized D+/D- and the one-cycle sample strobe from the RX clock divider, and performs NRZI decoding, SYNC detection, bit unstuffing, EOP detection and LSB-first byte assembly. Emits one-cycle byte strobes and status pulses to the RX packet controller.

---
 rtl/usb_rx_pkg.sv | 27 ++
 rtl/rx_nrzi_unstuff.sv | 70 +++++++
 rtl/usb_rx_bit_decoder.sv | 213 +++++++++++++++++++++
 tb/tb_usb_rx_bit_decoder.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB full-speed receive bit decoder.
package usb_rx_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    DATA = 3'd2,
    EOP  = 3'd3,
    ERR  = 3'd4
  } rx_state_t;

  // Encoded directly as {D+, D-} so a bus line maps onto a literal
  typedef enum logic [1:0] {
    SE0 = 2'b00,
    K   = 2'b01,
    J   = 2'b10,
    SE1 = 2'b11
  } line_state_t;

  localparam logic [7:0] SYNC_PATTERN = 8'h80;
  localparam logic [2:0] STUFF_LIMIT  = 3'd6;

  function automatic line_state_t decode_line(input logic dp, input logic dm);
    return line_state_t'({dp, dm});
  endfunction

endpackage

// File: rtl/rx_nrzi_unstuff.sv
// NRZI decoder and ones counter for the USB receive path.
// Optional macro RX_STUFF_ERR_EN adds the stuffViol_o output flagging a
// 1 where a stuff bit was due; without it the stuff bit is dropped silently.
module rx_nrzi_unstuff
  import usb_rx_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       strobe_i,
  input  logic [1:0] line_i,
  input  logic       idle_i,
  input  logic       dataMode_i,
  output logic       bit_o,
  output logic       bitValid_o
`ifdef RX_STUFF_ERR_EN
  ,
  output logic       stuffViol_o
`endif
);

  line_state_t line;
  line_state_t prevLevel_q, prevLevel_d;
  logic [2:0]  ones_q, ones_d;
  logic        isJK;
  logic        atStuff;

  assign line    = line_state_t'(line_i);
  assign isJK    = (line == J) || (line == K);
  assign atStuff = dataMode_i && (ones_q == STUFF_LIMIT);

  // A repeated level decodes as 1, a transition as 0
  assign bit_o      = (line == prevLevel_q);
  assign bitValid_o = strobe_i && isJK && !atStuff;

`ifdef RX_STUFF_ERR_EN
  assign stuffViol_o = strobe_i && isJK && atStuff && bit_o;
`endif

  // Track the last J/K level (held at J while idle) and the run of decoded 1s in DATA
  always_comb begin
    prevLevel_d = prevLevel_q;
    ones_d      = ones_q;
    if (strobe_i && isJK) begin
      prevLevel_d = line;
    end else if (idle_i) begin
      prevLevel_d = J;
    end
    if (!dataMode_i) begin
      ones_d = 3'd0;
    end else if (strobe_i && isJK) begin
      if (atStuff || !bit_o) begin
        ones_d = 3'd0;
      end else begin
        ones_d = ones_q + 3'd1;
      end
    end
  end

  // Register the previous level and ones count
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      prevLevel_q <= J;
      ones_q      <= 3'd0;
    end else begin
      prevLevel_q <= prevLevel_d;
      ones_q      <= ones_d;
    end
  end

endmodule

// File: rtl/usb_rx_bit_decoder.sv
// USB full-speed receive bit decoder: SYNC detection, byte assembly,
// EOP detection and error recovery around the NRZI/unstuff front end.
// Optional macro RX_STUFF_ERR_EN enables the bit-stuff violation check
// and the rx_stuff_err pulse; otherwise rx_stuff_err is tied low.
module usb_rx_bit_decoder
  import usb_rx_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       dp_sync,
  input  logic       dm_sync,
  input  logic       sample_strobe,
  input  logic       rx_en,
  output logic [7:0] rx_data,
  output logic       rx_byte_valid,
  output logic       rx_active,
  output logic       rx_eop,
  output logic       rx_align_err,
  output logic       rx_stuff_err
);

  line_state_t line;
  logic        strobe;
  logic        nrziBit;
  logic        bitValid;
  logic        stuffViol;

  rx_state_t   state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [3:0]  syncCnt_q, syncCnt_d;
  logic [2:0]  bitCnt_q, bitCnt_d;
  logic        eopSecond_q, eopSecond_d;
  logic [1:0]  se0Run_q, se0Run_d;
  logic [2:0]  jRun_q, jRun_d;
  logic [7:0]  rxData_q, rxData_d;
  logic        byteValid_q, byteValid_d;
  logic        active_q, active_d;
  logic        eop_q, eop_d;
  logic        alignErr_q, alignErr_d;
  logic        stuffErr_q, stuffErr_d;

  assign line   = decode_line(dp_sync, dm_sync);
  assign strobe = sample_strobe && rx_en;

  rx_nrzi_unstuff u_nrzi (
    .clk        (clk),
    .n_rst      (n_rst),
    .strobe_i   (strobe),
    .line_i     ({dp_sync, dm_sync}),
    .idle_i     (state_q == IDLE),
    .dataMode_i (state_q == DATA),
    .bit_o      (nrziBit),
    .bitValid_o (bitValid)
`ifdef RX_STUFF_ERR_EN
    ,
    .stuffViol_o(stuffViol)
`endif
  );

`ifndef RX_STUFF_ERR_EN
  assign stuffViol = 1'b0;
`endif

  // Next-state logic: receive FSM, shift register, counters and output pulses
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    syncCnt_d   = syncCnt_q;
    bitCnt_d    = bitCnt_q;
    eopSecond_d = eopSecond_q;
    se0Run_d    = se0Run_q;
    jRun_d      = jRun_q;
    rxData_d    = rxData_q;
    byteValid_d = 1'b0;
    eop_d       = 1'b0;
    alignErr_d  = 1'b0;
    stuffErr_d  = 1'b0;

    if (!rx_en) begin
      state_d     = IDLE;
      syncCnt_d   = 4'd0;
      bitCnt_d    = 3'd0;
      eopSecond_d = 1'b0;
      se0Run_d    = 2'd0;
      jRun_d      = 3'd0;
    end else if (strobe) begin
      unique case (state_q)
        IDLE: begin
          if (line == K) begin
            state_d   = SYNC;
            shift_d   = 8'h00;
            syncCnt_d = 4'd1;
          end
        end
        SYNC: begin
          if (line == SE1) begin
            state_d = ERR;
          end else if (line == SE0) begin
            state_d = IDLE;
          end else begin
            shift_d   = {nrziBit, shift_q[7:1]};
            syncCnt_d = syncCnt_q + 4'd1;
            if (shift_d == SYNC_PATTERN) begin
              state_d  = DATA;
              bitCnt_d = 3'd0;
            end else if (syncCnt_q >= 4'd8) begin
              state_d = IDLE;
            end
          end
        end
        DATA: begin
          if (line == SE1) begin
            state_d = ERR;
          end else if (line == SE0) begin
            state_d     = EOP;
            eopSecond_d = 1'b0;
          end else if (stuffViol) begin
            state_d    = ERR;
            stuffErr_d = 1'b1;
          end else if (bitValid) begin
            shift_d  = {nrziBit, shift_q[7:1]};
            bitCnt_d = bitCnt_q + 3'd1;
            if (bitCnt_q == 3'd7) begin
              rxData_d    = shift_d;
              byteValid_d = 1'b1;
            end
          end
        end
        EOP: begin
          if (line == SE0 && !eopSecond_q) begin
            eopSecond_d = 1'b1;
          end else if (line == J && eopSecond_q) begin
            state_d    = IDLE;
            eop_d      = 1'b1;
            alignErr_d = (bitCnt_q != 3'd0);
          end else begin
            state_d = ERR;
          end
        end
        ERR: begin
          if (line == SE0) begin
            se0Run_d = (se0Run_q == 2'd2) ? 2'd2 : se0Run_q + 2'd1;
            jRun_d   = 3'd0;
          end else if (line == J) begin
            se0Run_d = 2'd0;
            if (se0Run_q == 2'd2 || jRun_q == 3'd6) begin
              state_d = IDLE;
              jRun_d  = 3'd0;
            end else begin
              jRun_d = jRun_q + 3'd1;
            end
          end else begin
            se0Run_d = 2'd0;
            jRun_d   = 3'd0;
          end
        end
        default: state_d = IDLE;
      endcase

      if (state_d == ERR && state_q != ERR) begin
        se0Run_d = 2'd0;
        jRun_d   = 3'd0;
      end
    end

    active_d = (state_d == DATA) || (state_d == EOP);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      shift_q     <= 8'h00;
      syncCnt_q   <= 4'd0;
      bitCnt_q    <= 3'd0;
      eopSecond_q <= 1'b0;
      se0Run_q    <= 2'd0;
      jRun_q      <= 3'd0;
      rxData_q    <= 8'h00;
      byteValid_q <= 1'b0;
      active_q    <= 1'b0;
      eop_q       <= 1'b0;
      alignErr_q  <= 1'b0;
      stuffErr_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      syncCnt_q   <= syncCnt_d;
      bitCnt_q    <= bitCnt_d;
      eopSecond_q <= eopSecond_d;
      se0Run_q    <= se0Run_d;
      jRun_q      <= jRun_d;
      rxData_q    <= rxData_d;
      byteValid_q <= byteValid_d;
      active_q    <= active_d;
      eop_q       <= eop_d;
      alignErr_q  <= alignErr_d;
      stuffErr_q  <= stuffErr_d;
    end
  end

  assign rx_data       = rxData_q;
  assign rx_byte_valid = byteValid_q;
  assign rx_active     = active_q;
  assign rx_eop        = eop_q;
  assign rx_align_err  = alignErr_q;
`ifdef RX_STUFF_ERR_EN
  assign rx_stuff_err  = stuffErr_q;
`else
  assign rx_stuff_err  = 1'b0;
`endif

endmodule

// File: tb/tb_usb_rx_bit_decoder.sv
// Scoreboard testbench for usb_rx_bit_decoder.
// Expected events are queued as packets are driven; the negedge monitor pops
// and compares each pulse the decoder produces. Honours RX_STUFF_ERR_EN.
module tb_usb_rx_bit_decoder;

  localparam logic [1:0] LSE0 = 2'b00;
  localparam logic [1:0] LK   = 2'b01;
  localparam logic [1:0] LJ   = 2'b10;
  localparam logic [1:0] LSE1 = 2'b11;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       dp_sync = 1'b1;
  logic       dm_sync = 1'b0;
  logic       sample_strobe = 1'b0;
  logic       rx_en = 1'b0;
  logic [7:0] rx_data;
  logic       rx_byte_valid;
  logic       rx_active;
  logic       rx_eop;
  logic       rx_align_err;
  logic       rx_stuff_err;

  int         compared = 0;
  int         mismatched = 0;
  logic [11:0] expQ[$];
  logic [11:0] obsWord;
  logic [11:0] expWord;
  logic [1:0] level = LJ;
  int         onesRun = 0;
  int         dataBits = 0;

  usb_rx_bit_decoder dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .dp_sync      (dp_sync),
    .dm_sync      (dm_sync),
    .sample_strobe(sample_strobe),
    .rx_en        (rx_en),
    .rx_data      (rx_data),
    .rx_byte_valid(rx_byte_valid),
    .rx_active    (rx_active),
    .rx_eop       (rx_eop),
    .rx_align_err (rx_align_err),
    .rx_stuff_err (rx_stuff_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, actual, expected);
    end
  endtask

  // One line sample with its strobe, then idle so strobes are 3 clk apart
  task automatic applyStimulus(input logic [1:0] ls);
    @(posedge clk);
    #1;
    {dp_sync, dm_sync} = ls;
    sample_strobe = 1'b1;
    @(posedge clk);
    #1;
    sample_strobe = 1'b0;
    @(posedge clk);
  endtask

  // NRZI: a 0 toggles the line level, a 1 repeats it
  task automatic sendRaw(input logic b);
    if (!b) level = (level == LJ) ? LK : LJ;
    applyStimulus(level);
  endtask

  task automatic sendSync();
    level = LJ;
    repeat (7) sendRaw(1'b0);
    sendRaw(1'b1);
    onesRun  = 0;
    dataBits = 0;
  endtask

  task automatic sendDataBit(input logic b);
    sendRaw(b);
    dataBits++;
    if (b) onesRun++;
    else onesRun = 0;
    if (onesRun == 6) begin
      sendRaw(1'b0);
      onesRun = 0;
    end
  endtask

  task automatic sendByte(input logic [7:0] v);
    expQ.push_back({4'b1000, v});
    for (int i = 0; i < 8; i++) sendDataBit(v[i]);
  endtask

  task automatic sendEop();
    logic align;
    align = ((dataBits % 8) != 0);
    expQ.push_back({1'b0, 1'b1, align, 1'b0, 8'h00});
    applyStimulus(LSE0);
    applyStimulus(LSE0);
    applyStimulus(LJ);
    level = LJ;
  endtask

  task automatic drainCheck(input string tag);
    repeat (2) @(negedge clk);
    checkOutput(tag, expQ.size(), 0);
  endtask

  // Scoreboard monitor: every pulse must match the next queued expectation
  always @(negedge clk) begin
    if (n_rst && (rx_byte_valid || rx_eop || rx_align_err || rx_stuff_err)) begin
      obsWord = {rx_byte_valid, rx_eop, rx_align_err, rx_stuff_err,
                 rx_byte_valid ? rx_data : 8'h00};
      if (expQ.size() == 0) begin
        checkOutput("unexpected event", obsWord, 12'h000);
      end else begin
        expWord = expQ.pop_front();
        checkOutput("event", obsWord, expWord);
      end
    end
  end

  initial begin
    #2_000_000;
    mismatched++;
    $display("[TB] FAIL watchdog: simulation did not complete, wanted completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting usb_rx_bit_decoder bench");
    {dp_sync, dm_sync} = LJ;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset rx_data", rx_data, 8'h00);
    checkOutput("reset rx_active", rx_active, 1'b0);
    checkOutput("reset pulses", {rx_byte_valid, rx_eop, rx_align_err, rx_stuff_err}, 4'h0);
    n_rst = 1'b1;
    rx_en = 1'b1;
    repeat (2) @(posedge clk);

    // Plain byte A5 followed by a clean EOP
    sendSync();
    @(negedge clk);
    checkOutput("active after sync", rx_active, 1'b1);
    sendByte(8'hA5);
    sendEop();
    drainCheck("A5 drain");
    checkOutput("active after eop", rx_active, 1'b0);
    checkOutput("rx_data A5", rx_data, 8'hA5);

    // Byte FF needs one stuffed 0 after six 1s
    sendSync();
    sendByte(8'hFF);
    sendEop();
    drainCheck("FF drain");
    checkOutput("rx_data FF", rx_data, 8'hFF);

    // Five data bits then EOP: alignment error, no byte
    sendSync();
    sendDataBit(1'b1);
    sendDataBit(1'b0);
    sendDataBit(1'b1);
    sendDataBit(1'b1);
    sendDataBit(1'b0);
    sendEop();
    drainCheck("align drain");
    checkOutput("rx_data held FF", rx_data, 8'hFF);

    // Seven raw 1s after SYNC
    sendSync();
`ifdef RX_STUFF_ERR_EN
    expQ.push_back({4'b0001, 8'h00});
    repeat (7) sendRaw(1'b1);
    @(negedge clk);
    checkOutput("active after stuff err", rx_active, 1'b0);
    applyStimulus(LSE0);
    applyStimulus(LSE0);
    applyStimulus(LJ);
    level = LJ;
    drainCheck("stuff err drain");
`else
    expQ.push_back({4'b1000, 8'hBF});
    repeat (7) sendRaw(1'b1);
    @(negedge clk);
    checkOutput("active through stuff 1", rx_active, 1'b1);
    sendRaw(1'b0);
    sendRaw(1'b1);
    dataBits = 8;
    sendEop();
    drainCheck("stuff discard drain");
    checkOutput("rx_data BF", rx_data, 8'hBF);
`endif

    // SE1 mid-DATA, recovery via SE0 SE0 J, then a fresh packet
    sendSync();
    sendDataBit(1'b1);
    sendDataBit(1'b0);
    sendDataBit(1'b1);
    applyStimulus(LSE1);
    @(negedge clk);
    checkOutput("active after SE1", rx_active, 1'b0);
    applyStimulus(LSE0);
    applyStimulus(LSE0);
    applyStimulus(LJ);
    level = LJ;
    sendSync();
    @(negedge clk);
    checkOutput("active after resync", rx_active, 1'b1);
    sendByte(8'h3C);
    sendEop();
    drainCheck("resync drain");
    checkOutput("rx_data 3C", rx_data, 8'h3C);

    // rx_en dropped mid-DATA: back to idle, data held, no pulses
    sendSync();
    sendDataBit(1'b1);
    sendDataBit(1'b1);
    sendDataBit(1'b0);
    @(posedge clk);
    #1;
    rx_en = 1'b0;
    applyStimulus(LSE0);
    @(negedge clk);
    checkOutput("active with rx_en low", rx_active, 1'b0);
    checkOutput("rx_data held 3C", rx_data, 8'h3C);
    @(posedge clk);
    #1;
    rx_en = 1'b1;
    {dp_sync, dm_sync} = LJ;
    level = LJ;
    applyStimulus(LJ);
    sendSync();
    sendByte(8'h5A);
    sendEop();
    drainCheck("rx_en drain");
    checkOutput("rx_data 5A", rx_data, 8'h5A);

    // Asynchronous reset in the middle of a byte
    sendSync();
    sendDataBit(1'b1);
    sendDataBit(1'b0);
    @(posedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    checkOutput("mid reset rx_active", rx_active, 1'b0);
    checkOutput("mid reset rx_data", rx_data, 8'h00);
    checkOutput("mid reset pulses", {rx_byte_valid, rx_eop, rx_align_err, rx_stuff_err}, 4'h0);
    @(posedge clk);
    #1;
    {dp_sync, dm_sync} = LJ;
    level = LJ;
    n_rst = 1'b1;
    repeat (2) @(posedge clk);
    sendSync();
    sendByte(8'h81);
    sendEop();
    drainCheck("post reset drain");
    checkOutput("rx_data 81", rx_data, 8'h81);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
